// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable shift-register pattern matcher on a 1-bit stream.
// Optional RUN-cycle timeout is built only when SEQ_DET_TIMEOUT_EN is defined.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PAT_W-1:0]       cfg_pattern,
  input  logic [$clog2(PAT_W):0] cfg_len,
  input  logic                   cfg_overlap,
  input  logic [CNT_W-1:0]       cfg_limit,
  input  logic [TO_W-1:0]        cfg_timeout,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   seq_valid,
  input  logic                   seq_in,
  output logic                   detect_out,
  output logic [CNT_W-1:0]       match_count,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out
);

  localparam int LW = $clog2(PAT_W) + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(PAT_W);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   lim_q;
  logic [PAT_W-1:0]   hist;
  logic [LW-1:0]      fill;

  logic [LW-1:0]      len_clamp;
  logic [PAT_W-1:0]   hist_nxt;
  logic [LW-1:0]      fill_nxt;
  logic [PAT_W-1:0]   mask;
  logic               match;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               limit_hit;
  logic               load_cfg;
  logic               enter_run;
  logic               unused_hist_msb;

  assign unused_hist_msb = hist[PAT_W-1];

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0)
      len_clamp = LW'(1);
    else if (cfg_len > LEN_MAX)
      len_clamp = LEN_MAX;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len_q));
  end

  assign hist_nxt = {hist[PAT_W-2:0], seq_in};
  assign fill_nxt = (fill >= len_q) ? len_q : fill + 1'b1;

  // Abort outranks the datapath, so an aborted cycle can never produce a match.
  assign match = (state == RUN) && !abort && seq_valid &&
                 (fill_nxt >= len_q) &&
                 ((hist_nxt & mask) == (pat_q & mask));

  assign cnt_nxt   = (&match_count) ? match_count : match_count + 1'b1;
  assign limit_hit = match && (lim_q != '0) && (cnt_nxt == lim_q);

  // Config is taken in IDLE, or in ARMED/DONE only when neither abort nor start claims the cycle.
  assign load_cfg  = cfg_valid &&
                     ((state == IDLE) ||
                      (((state == ARMED) || (state == DONE)) && !abort && !start));
  assign enter_run = start && !abort && ((state == ARMED) || (state == DONE));

`ifdef SEQ_DET_TIMEOUT_EN
  logic [TO_W-1:0] tmo_q;
  logic [TO_W-1:0] timer;
  logic            tmo_hit;

  assign tmo_hit = (state == RUN) && !abort && !match &&
                   (tmo_q != '0) && (timer == tmo_q - 1'b1);
`else
  logic unused_cfg_timeout;

  assign unused_cfg_timeout = ^cfg_timeout;
  assign timed_out          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      lim_q       <= '0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      detect_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
      tmo_q       <= '0;
      timer       <= '0;
      timed_out   <= 1'b0;
`endif
    end else begin
      detect_out <= match;

      if (load_cfg) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamp;
        ovl_q <= cfg_overlap;
        lim_q <= cfg_limit;
`ifdef SEQ_DET_TIMEOUT_EN
        tmo_q <= cfg_timeout;
`endif
      end

      if (enter_run) begin
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
        timer       <= '0;
        timed_out   <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (load_cfg)
            state <= ARMED;
        end

        ARMED: begin
          if (abort) begin
            state <= IDLE;
          end else if (enter_run) begin
            state     <= RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end

        RUN: begin
          if (abort) begin
            state     <= ARMED;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            if (seq_valid) begin
              hist <= hist_nxt;
              // Non-overlapping mode demands len fresh bits before the next match.
              fill <= (match && !ovl_q) ? '0 : fill_nxt;
            end
            if (match)
              match_count <= cnt_nxt;
`ifdef SEQ_DET_TIMEOUT_EN
            timer <= match ? '0 : timer + 1'b1;
`endif
            if (limit_hit) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
            end
`ifdef SEQ_DET_TIMEOUT_EN
            else if (tmo_hit) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
              timed_out <= 1'b1;
            end
`endif
          end
        end

        DONE: begin
          if (abort || load_cfg) begin
            state <= ARMED;
            done  <= 1'b0;
          end else if (enter_run) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
